// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - AXI4 read-channel responder with fixed latency and address-derived data
//
// Accepts AR requests into an in-order queue and returns R bursts whose beat
// data is the low DATA_WIDTH bits of the beat address. The head request is
// served no earlier than LATENCY cycles after its AR handshake.
//
// Optional feature macro: AXI_RD_RESP_DECERR_EN
//   defined   : beats with beat address >= ERR_LIMIT return resp=2'b11, data=0
//   undefined : resp is always 2'b00, ERR_LIMIT has no effect
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   s_ar_valid/ready         AR handshake
//   s_ar_addr/len/id         burst start address, beats-1, transaction ID
//   s_r_valid/ready          R handshake
//   s_r_data/id/last/resp    beat data, echoed ID, last-beat flag, response
//   busy                     queue holds at least one request

module axi_rd_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int LOG_BYTES  = 0,
    parameter int LOG_DEPTH  = 3,
    parameter int LATENCY    = 4,
    parameter int CNT_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] ERR_LIMIT = 16'hC000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_ar_valid,
    output logic                  s_ar_ready,
    input  logic [ADDR_WIDTH-1:0] s_ar_addr,
    input  logic [LEN_WIDTH-1:0]  s_ar_len,
    input  logic [ID_WIDTH-1:0]   s_ar_id,
    output logic                  s_r_valid,
    input  logic                  s_r_ready,
    output logic [DATA_WIDTH-1:0] s_r_data,
    output logic [ID_WIDTH-1:0]   s_r_id,
    output logic                  s_r_last,
    output logic [1:0]            s_r_resp,
    output logic                  busy
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    // Request queue storage (no reset needed: only read when non-empty)
    logic [ADDR_WIDTH-1:0] r_q_addr  [DEPTH];
    logic [LEN_WIDTH-1:0]  r_q_len   [DEPTH];
    logic [ID_WIDTH-1:0]   r_q_id    [DEPTH];
    logic [CNT_WIDTH-1:0]  r_q_stamp [DEPTH];

    logic [LOG_DEPTH:0]    r_wr_ptr;
    logic [LOG_DEPTH:0]    r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_now;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic                  r_started;

    logic [LOG_DEPTH-1:0]  w_wr_idx;
    logic [LOG_DEPTH-1:0]  w_rd_idx;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic [CNT_WIDTH-1:0]  w_age;
    logic                  w_eligible;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_beat_hs;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [DATA_WIDTH-1:0] w_addr_data;

    assign w_wr_idx = r_wr_ptr[LOG_DEPTH-1:0];
    assign w_rd_idx = r_rd_ptr[LOG_DEPTH-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]) && (w_wr_idx == w_rd_idx);

    // Ready depends only on the registered fill level, so a pop in the same
    // cycle never frees a slot for a push.
    assign s_ar_ready = !rst && !w_full;
    assign w_push     = s_ar_valid && s_ar_ready;

    // Age of the head request, modulo the counter width.
    assign w_age      = r_now - r_q_stamp[w_rd_idx];
    assign w_eligible = (w_age >= CNT_WIDTH'(LATENCY));

    // r_started keeps valid asserted under long backpressure even if the age
    // comparison would wrap around.
    assign w_valid   = !w_empty && (r_started || w_eligible);
    assign w_last    = (r_beat == r_q_len[w_rd_idx]);
    assign w_beat_hs = w_valid && s_r_ready;
    assign w_pop     = w_beat_hs && w_last;

    assign w_beat_addr = r_q_addr[w_rd_idx] + (ADDR_WIDTH'(r_beat) << LOG_BYTES);

    generate
        if (DATA_WIDTH <= ADDR_WIDTH) begin : g_data_trunc
            assign w_addr_data = w_beat_addr[DATA_WIDTH-1:0];
        end else begin : g_data_ext
            assign w_addr_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_beat_addr};
        end
    endgenerate

    assign s_r_valid = w_valid;
    assign s_r_id    = w_valid ? r_q_id[w_rd_idx] : '0;
    assign s_r_last  = w_valid && w_last;
    assign busy      = !w_empty;

`ifdef AXI_RD_RESP_DECERR_EN
    logic w_err;
    assign w_err    = (w_beat_addr >= ERR_LIMIT);
    assign s_r_resp = (w_valid && w_err) ? 2'b11 : 2'b00;
    assign s_r_data = (w_valid && !w_err) ? w_addr_data : '0;
`else
    logic w_unused_err;
    assign w_unused_err = (w_beat_addr >= ERR_LIMIT);
    assign s_r_resp     = 2'b00;
    assign s_r_data     = w_valid ? w_addr_data : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_now     <= '0;
            r_beat    <= '0;
            r_started <= 1'b0;
        end else begin
            r_now <= r_now + CNT_WIDTH'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (LOG_DEPTH+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + (LOG_DEPTH+1)'(1);
                r_beat    <= '0;
                r_started <= 1'b0;
            end else begin
                if (w_beat_hs) begin
                    r_beat <= r_beat + LEN_WIDTH'(1);
                end
                if (w_valid) begin
                    r_started <= 1'b1;
                end
            end
        end
    end

    // Stamp with the count that becomes current at this edge, so the head
    // becomes eligible exactly LATENCY edges after its handshake.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[w_wr_idx]  <= s_ar_addr;
            r_q_len[w_wr_idx]   <= s_ar_len;
            r_q_id[w_wr_idx]    <= s_ar_id;
            r_q_stamp[w_wr_idx] <= r_now + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// tb/tb_axi_rd_responder.sv - self-checking bench for axi_rd_responder

module tb_axi_rd_responder;

    localparam int LAT = 4;

    typedef struct {
        logic [7:0] data;
        logic [7:0] id;
        logic       last;
        logic [1:0] resp;
        int         cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_ar_valid = 1'b0;
    logic        s_ar_ready;
    logic [15:0] s_ar_addr = '0;
    logic [7:0]  s_ar_len = '0;
    logic [7:0]  s_ar_id = '0;
    logic        s_r_valid;
    logic        s_r_ready = 1'b0;
    logic [7:0]  s_r_data;
    logic [7:0]  s_r_id;
    logic        s_r_last;
    logic [1:0]  s_r_resp;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ar_cyc = 0;
    int n_ar_acc = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    axi_rd_responder dut (
        .clk        (clk),
        .rst        (rst),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_ar_addr  (s_ar_addr),
        .s_ar_len   (s_ar_len),
        .s_ar_id    (s_ar_id),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .s_r_data   (s_r_data),
        .s_r_id     (s_r_id),
        .s_r_last   (s_r_last),
        .s_r_resp   (s_r_resp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic beat_t model(input logic [15:0] a, input logic [7:0] l,
                                    input logic [7:0] id, input int n);
        beat_t b;
        logic [15:0] ba;
        ba     = a + 16'(n);
        b.data = ba[7:0];
        b.id   = id;
        b.last = (n == int'(l));
        b.resp = 2'b00;
        b.cyc  = 0;
`ifdef AXI_RD_RESP_DECERR_EN
        if (ba >= 16'hC000) begin
            b.data = 8'h00;
            b.resp = 2'b11;
        end
`endif
        return b;
    endfunction

    // Handshakes are decided on the next rising edge; record them mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        if (!rst && s_r_valid && s_r_ready) begin
            b.data = s_r_data;
            b.id   = s_r_id;
            b.last = s_r_last;
            b.resp = s_r_resp;
            b.cyc  = cyc;
            obs_q.push_back(b);
        end
        if (!rst && s_ar_valid && s_ar_ready) begin
            n_ar_acc++;
            ar_cyc = cyc;
            for (int n = 0; n <= int'(s_ar_len); n++)
                exp_q.push_back(model(s_ar_addr, s_ar_len, s_ar_id, n));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [15:0] a, input logic [7:0] l,
                           input logic [7:0] i, output bit ok);
        s_ar_addr  = a;
        s_ar_len   = l;
        s_ar_id    = i;
        s_ar_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = s_ar_ready;
            tick();
        end
        s_ar_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if (s_ar_ready !== 1'b0 || s_r_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ar_ready=%b r_valid=%b busy=%b, want 0 0 0", s_ar_ready, s_r_valid, busy);
        end
        tests++;
        if (s_r_data !== 8'h00 || s_r_id !== 8'h00 || s_r_last !== 1'b0 || s_r_resp !== 2'b00) begin
            fails++;
            $display("FAIL reset_r: data=%h id=%h last=%b resp=%b, want 00 00 0 00", s_r_data, s_r_id, s_r_last, s_r_resp);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (s_ar_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ar_ready=%b busy=%b, want 1 0", s_ar_ready, busy);
        end
    endtask

    task automatic test_single();
        beat_t e, o;
        bit ok;
        int c0;
        s_r_ready = 1'b1;
        send_ar(16'h5940, 8'd0, 8'd5, ok);
        c0 = ar_cyc;
        tests++;
        if (!ok) begin fails++; $display("FAIL single_ar: accepted=%b, want 1", ok); end
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) tick();
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL single_count: beats=%0d, want 1", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0].cyc - c0 != LAT + 1) begin
                fails++;
                $display("FAIL single_latency: cycles=%0d, want %0d", obs_q[0].cyc - c0, LAT + 1);
            end
        end
        tests++;
        if (busy !== 1'b0 || s_r_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: busy=%b r_valid=%b, want 0 0", busy, s_r_valid);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.data !== e.data || o.id !== e.id || o.last !== e.last || o.resp !== e.resp) begin
                fails++;
                $display("FAIL single_beat: got %h/%h/%b/%b, want %h/%h/%b/%b", o.data, o.id, o.last, o.resp, e.data, e.id, e.last, e.resp);
            end
        end
    endtask

    task automatic test_burst_wrap();
        beat_t e, o;
        bit ok;
        s_r_ready = 1'b1;
        send_ar(16'hFFFE, 8'd3, 8'd1, ok);
        for (int k = 0; k < 30 && obs_q.size() < 4; k++) tick();
        tests++;
        if (obs_q.size() != 4) begin
            fails++;
            $display("FAIL wrap_count: beats=%0d, want 4", obs_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                tests++;
                if (obs_q[i].cyc - obs_q[i-1].cyc != 1) begin
                    fails++;
                    $display("FAIL wrap_gap: beat %0d gap=%0d, want 1", i, obs_q[i].cyc - obs_q[i-1].cyc);
                end
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.data !== e.data || o.id !== e.id || o.last !== e.last || o.resp !== e.resp) begin
                fails++;
                $display("FAIL wrap_beat: got %h/%h/%b/%b, want %h/%h/%b/%b", o.data, o.id, o.last, o.resp, e.data, e.id, e.last, e.resp);
            end
        end
        tick();
    endtask

    task automatic test_full_queue();
        beat_t e, o;
        int base;
        base = n_ar_acc;
        s_r_ready  = 1'b0;
        s_ar_len   = 8'd0;
        s_ar_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            s_ar_addr = 16'h1000 + 16'(3 * (n_ar_acc - base));
            s_ar_id   = 8'(16 + n_ar_acc - base);
            if (n_ar_acc - base == 8) break;
            tick();
        end
        tests++;
        if (s_ar_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL full_ready: ar_ready=%b busy=%b, want 0 1", s_ar_ready, busy);
        end
        repeat (6) tick();
        tests++;
        if (n_ar_acc - base != 8) begin
            fails++;
            $display("FAIL full_stall: accepted=%0d, want 8", n_ar_acc - base);
        end
        s_r_ready = 1'b1;
        tick();
        tests++;
        if (s_ar_ready !== 1'b1 || obs_q.size() != 1) begin
            fails++;
            $display("FAIL full_after_pop: ar_ready=%b beats=%0d, want 1 1", s_ar_ready, obs_q.size());
        end
        tick();
        s_ar_valid = 1'b0;
        tests++;
        if (n_ar_acc - base != 9) begin
            fails++;
            $display("FAIL full_ninth: accepted=%0d, want 9", n_ar_acc - base);
        end
        for (int k = 0; k < 60 && obs_q.size() < 9; k++) tick();
        tests++;
        if (obs_q.size() != 9 || exp_q.size() != 9) begin
            fails++;
            $display("FAIL full_count: beats=%0d expected=%0d, want 9 9", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.data !== e.data || o.id !== e.id || o.last !== e.last || o.resp !== e.resp) begin
                fails++;
                $display("FAIL full_beat: got %h/%h/%b/%b, want %h/%h/%b/%b", o.data, o.id, o.last, o.resp, e.data, e.id, e.last, e.resp);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        beat_t e, o;
        bit ok, hold;
        logic [7:0] hd, hi;
        logic hl;
        logic [3:0] pat;
        int n_hold;
        pat = 4'b1001;
        hold = 1'b0;
        n_hold = 0;
        hd = '0; hi = '0; hl = 1'b0;
        s_r_ready = 1'b1;
        send_ar(16'h3A7C, 8'd2, 8'h22, ok);
        for (int k = 0; k < 40; k++) begin
            if (hold) begin
                n_hold++;
                tests++;
                if (s_r_valid !== 1'b1 || s_r_data !== hd || s_r_id !== hi || s_r_last !== hl) begin
                    fails++;
                    $display("FAIL bp_stable: valid=%b data=%h id=%h last=%b, want 1 %h %h %b", s_r_valid, s_r_data, s_r_id, s_r_last, hd, hi, hl);
                end
            end
            s_r_ready = pat[k % 4];
            hold = s_r_valid && !s_r_ready;
            hd = s_r_data;
            hi = s_r_id;
            hl = s_r_last;
            tick();
        end
        tests++;
        if (n_hold == 0 || obs_q.size() != 3) begin
            fails++;
            $display("FAIL bp_count: holds=%0d beats=%0d, want >0 3", n_hold, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.data !== e.data || o.id !== e.id || o.last !== e.last || o.resp !== e.resp) begin
                fails++;
                $display("FAIL bp_beat: got %h/%h/%b/%b, want %h/%h/%b/%b", o.data, o.id, o.last, o.resp, e.data, e.id, e.last, e.resp);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        beat_t e, o;
        bit ok, any_valid;
        int c0;
        s_r_ready = 1'b1;
        send_ar(16'h2200, 8'd3, 8'd9, ok);
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) tick();
        tests++;
        if (s_r_valid !== 1'b1 || s_r_data !== 8'h01) begin
            fails++;
            $display("FAIL rmb_beat1: valid=%b data=%h, want 1 01", s_r_valid, s_r_data);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (s_r_valid !== 1'b0 || s_ar_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rmb_async: valid=%b ar_ready=%b busy=%b, want 0 0 0", s_r_valid, s_ar_ready, busy);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.data !== e.data || o.id !== e.id || o.last !== e.last || o.resp !== e.resp) begin
                fails++;
                $display("FAIL rmb_beat0: got %h/%h/%b/%b, want %h/%h/%b/%b", o.data, o.id, o.last, o.resp, e.data, e.id, e.last, e.resp);
            end
        end
        exp_q.delete();
        obs_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        any_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_r_valid) any_valid = 1'b1;
        end
        tests++;
        if (any_valid || obs_q.size() != 0) begin
            fails++;
            $display("FAIL rmb_silent: saw_valid=%b beats=%0d, want 0 0", any_valid, obs_q.size());
        end
        send_ar(16'h0A0B, 8'd0, 8'd7, ok);
        c0 = ar_cyc;
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) tick();
        tests++;
        if (obs_q.size() != 1 || obs_q[0].cyc - c0 != LAT + 1) begin
            fails++;
            $display("FAIL rmb_new_latency: beats=%0d cycles=%0d, want 1 %0d", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].cyc - c0 : -1, LAT + 1);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.data !== e.data || o.id !== e.id || o.last !== e.last || o.resp !== e.resp) begin
                fails++;
                $display("FAIL rmb_new_beat: got %h/%h/%b/%b, want %h/%h/%b/%b", o.data, o.id, o.last, o.resp, e.data, e.id, e.last, e.resp);
            end
        end
    endtask

`ifdef AXI_RD_RESP_DECERR_EN
    task automatic test_decerr();
        beat_t e, o;
        bit ok;
        s_r_ready = 1'b1;
        send_ar(16'hBFFF, 8'd1, 8'd3, ok);
        for (int k = 0; k < 20 && obs_q.size() < 2; k++) tick();
        tests++;
        if (obs_q.size() != 2) begin
            fails++;
            $display("FAIL decerr_count: beats=%0d, want 2", obs_q.size());
        end else begin
            tests++;
            if (obs_q[1].resp !== 2'b11 || obs_q[1].data !== 8'h00 || obs_q[0].resp !== 2'b00) begin
                fails++;
                $display("FAIL decerr_resp: resp0=%b resp1=%b data1=%h, want 00 11 00", obs_q[0].resp, obs_q[1].resp, obs_q[1].data);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.data !== e.data || o.id !== e.id || o.last !== e.last || o.resp !== e.resp) begin
                fails++;
                $display("FAIL decerr_beat: got %h/%h/%b/%b, want %h/%h/%b/%b", o.data, o.id, o.last, o.resp, e.data, e.id, e.last, e.resp);
            end
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
        test_burst_wrap();
        test_full_queue();
        test_backpressure();
        test_reset_mid_burst();
`ifdef AXI_RD_RESP_DECERR_EN
        test_decerr();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
